decoder_scan_ctrl: RTL
======================

// Module: decoder_scan_ctrl
// PURPOSE
//  Upstream address sequencer for the 5-to-32 decoder: drives its A/Enable inputs.
//  - On a start pulse, steps A from first_addr to last_addr, ascending mod 2**ADDR_W.
//  - Holds each address for a programmable dwell; Enable stays high while an address is valid.
//  - Signals completion with a one-cycle done pulse. Supports abort via stop.
// PARAMETERS
//  ADDR_W  5  address width; matches decoder select input (2**ADDR_W outputs)
//  DW      8  width of dwell count; each address held dwell+1 cycles
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-high reset
//  start       in   1       1-cycle request; sampled only in IDLE
//  stop        in   1       abort request; sampled every cycle
//  first_addr  in   ADDR_W  first address of scan; latched on accepted start
//  last_addr   in   ADDR_W  last address of scan; latched on accepted start
//  dwell       in   DW      extra hold cycles per address; latched on accepted start
//  A           out  ADDR_W  address to decoder
//  Enable      out  1       decoder enable
//  busy        out  1       high from first driven cycle until scan ends or aborts
//  done        out  1       1-cycle pulse after normal completion only
// BEHAVIOUR
//  Reset: state=IDLE, A=0, Enable=0, busy=0, done=0, internal counters=0. All outputs registered.
//  States:
//   - IDLE: wait for start.
//   - DRIVE: present A, Enable=1, count dwell.
//   - GAP: exists only with BLANK_GAP_EN.
//  IDLE->DRIVE:
//   - start=1 & stop=0 latches the inputs.
//   - Next cycle: A=first_addr, Enable=1, busy=1 (1-cycle latency).
//  DRIVE:
//   - dwell counter runs 0..dwell_latched; at the terminal count:
//     - A!=last: A<=A+1 mod 2**ADDR_W (31->0 wraps, no error). Stay in DRIVE, counter reset.
//     - A==last: go to IDLE; next cycle Enable=0, busy=0, done=1 for exactly one cycle.
//   - A holds the last driven value in IDLE.
//  Address count = ((last-first) mod 2**ADDR_W)+1. first==last drives one address.
//   - first=last+1 scans all 2**ADDR_W.
//  dwell=0: new address every cycle. Total busy cycles = count*(dwell+1), no GAP.
//  stop=1 while busy (any state, any counter value):
//   - Next cycle Enable=0, busy=0, done=0, state IDLE. A holds its value.
//  stop has priority over start. start & stop in the same IDLE cycle: ignored.
//  start while busy: ignored. No queuing; latched parameters unchanged.
//  Input changes on first/last/dwell while busy have no effect.
//  reset mid-scan: next cycle all outputs at reset values. No done pulse.
//  Enable is never high while state=IDLE. done and busy are never high together.
// CONFIGURATION
//  BLANK_GAP_EN defined:
//   - Between consecutive addresses, insert one GAP cycle: A already shows the next address, Enable=0.
//   - Then DRIVE with Enable=1. Gives break-before-make on decoder outputs.
//   - Busy cycles = count*(dwell+1)+(count-1). stop in GAP aborts the same as in DRIVE.
//  BLANK_GAP_EN undefined:
//   - No GAP state. Enable stays continuously high across address changes.
// TESTING
//  1. first=1,last=3,dwell=0, start @T:
//     - T+1..T+3: A=1,2,3, Enable=1, busy=1.
//     - T+4: Enable=0, busy=0, done=1, A=3.
//     - T+5: done=0.
//  2. first=30,last=1,dwell=1:
//     - A=30,30,31,31,0,0,1,1 with Enable=1.
//     - Then done=1 one cycle (wrap check).
//  3. first=0,last=31,dwell=0, stop while A=4:
//     - Next cycle Enable=0, busy=0, done stays 0, A=4.
//  4. start pulsed while busy mid-scan with new first_addr=9:
//     - Scan continues unchanged.
//     - Also, in IDLE, start=stop=1: busy stays 0.
//  5. reset asserted during DRIVE at A=7,dwell=5:
//     - Next cycle A=0, Enable=0, busy=0, done=0.
//     - A fresh start then scans normally.
//  6. BLANK_GAP_EN, first=1,last=2,dwell=0:
//     - (A,Enable) = (1,1), (2,0), (2,1).
//     - Then done=1. Without the macro: (1,1), (2,1), then done.

Source files
------------

// File: rtl/decoder_scan_ctrl_if.sv
// Bus between an address-scan requester and decoder_scan_ctrl: request/parameter inputs
// plus the registered decoder drive (A/Enable) and scan status outputs.
interface decoder_scan_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DW     = 8
);
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [DW-1:0]     dwell;
  logic [ADDR_W-1:0] A;
  logic              Enable;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, first_addr, last_addr, dwell,
    input  A, Enable, busy, done
  );

  modport slave (
    input  start, stop, first_addr, last_addr, dwell,
    output A, Enable, busy, done
  );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Address sequencer for a 2**ADDR_W-output decoder: scans first..last (mod 2**ADDR_W) with a
// per-address dwell. Optional macro BLANK_GAP_EN inserts a one-cycle Enable-low gap between addresses.
module decoder_scan_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DW     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  decoder_scan_ctrl_if.slave   bus
);

`ifdef BLANK_GAP_EN
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRIVE} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // stop outranks start; scan parameters are captured only here
        if (bus.start && !bus.stop) begin
          state_d = DRIVE;
          a_d     = bus.first_addr;
          last_d  = bus.last_addr;
          dwell_d = bus.dwell;
          cnt_d   = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end

      DRIVE: begin
        if (bus.stop) begin
          state_d = IDLE;
          cnt_d   = '0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q == dwell_q) begin
          cnt_d = '0;
          if (a_q == last_q) begin
            state_d = IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            a_d = a_q + ADDR_W'(1);
`ifdef BLANK_GAP_EN
            state_d = GAP;
            en_d    = 1'b0;
`endif
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end

`ifdef BLANK_GAP_EN
      GAP: begin
        // next address is already on A; Enable returns one cycle later
        if (bus.stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = DRIVE;
          en_d    = 1'b1;
        end
      end
`endif

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.A      = a_q;
  assign bus.Enable = en_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
